// File: rtl/noc_packetizer.sv
// noc_packetizer
//   Network-interface packetizer between a local core and the router LOCAL
//   input port. A request (destination, VC, length, head payload) plus a
//   stream of body payload words is turned into HEAD/BODY/TAIL/HEADTAIL
//   flits under per-VC credit flow control.
//
//   Optional feature macro: NOC_PKT_VC_RR_EN
//     defined     : req_vc is ignored; the VC comes from a round-robin pointer
//                   (reset 0) that advances once per accepted request.
//     not defined : the latched req_vc is used as given.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   req_valid/req_ready    packet request handshake
//   req_x_dest/req_y_dest  destination coordinates
//   req_vc                 requested VC
//   req_len                total flits including head (clamped to 1..MAX)
//   req_head_pl            head-flit payload
//   pl_valid/pl_ready      body payload handshake (pl_ready is combinational)
//   pl_data                body/tail payload
//   flit_valid/data/vc     registered flit output
//   credit_valid/vc        one credit returned by the downstream buffer
//   credit_ovf             sticky: credit returned to a VC already full
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for a request, req_ready=1
// HEAD  | request latched, head flit waits for a credit
// BODY  | body/tail flits wait for a credit and a payload word
module noc_packetizer #(
  parameter int FLIT_WIDTH    = 64,
  parameter int MESH_SIZE_X   = 4,
  parameter int MESH_SIZE_Y   = 4,
  parameter int VC_NUM        = 2,
  parameter int VC_DEPTH      = 4,
  parameter int MAX_PKT_FLITS = 8,
  localparam int X_W       = $clog2(MESH_SIZE_X),
  localparam int Y_W       = $clog2(MESH_SIZE_Y),
  localparam int VC_W      = (VC_NUM > 1) ? $clog2(VC_NUM) : 1,
  localparam int LEN_W     = $clog2(MAX_PKT_FLITS + 1),
  localparam int HEAD_PL_W = FLIT_WIDTH - 2 - X_W - Y_W,
  localparam int BODY_PL_W = FLIT_WIDTH - 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [X_W-1:0]        req_x_dest,
  input  logic [Y_W-1:0]        req_y_dest,
  input  logic [VC_W-1:0]       req_vc,
  input  logic [LEN_W-1:0]      req_len,
  input  logic [HEAD_PL_W-1:0]  req_head_pl,
  input  logic                  pl_valid,
  output logic                  pl_ready,
  input  logic [BODY_PL_W-1:0]  pl_data,
  output logic                  flit_valid,
  output logic [FLIT_WIDTH-1:0] flit_data,
  output logic [VC_W-1:0]       flit_vc,
  input  logic                  credit_valid,
  input  logic [VC_W-1:0]       credit_vc,
  output logic                  credit_ovf
);

  localparam int CRD_W = $clog2(VC_DEPTH + 1);

  localparam logic [1:0] LBL_HEAD     = 2'd0;
  localparam logic [1:0] LBL_BODY     = 2'd1;
  localparam logic [1:0] LBL_TAIL     = 2'd2;
  localparam logic [1:0] LBL_HEADTAIL = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HEAD = 2'd1,
    S_BODY = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [X_W-1:0]         x_q, x_d;
  logic [Y_W-1:0]         y_q, y_d;
  logic [VC_W-1:0]        vc_q, vc_d;
  logic [LEN_W-1:0]       len_q, len_d;
  logic [LEN_W-1:0]       rem_q, rem_d;
  logic [HEAD_PL_W-1:0]   head_pl_q, head_pl_d;
  logic [CRD_W-1:0]       credit_q [VC_NUM];
  logic [CRD_W-1:0]       credit_d [VC_NUM];
  logic                   ovf_q, ovf_d;
  logic                   flit_valid_q, flit_valid_d;
  logic [FLIT_WIDTH-1:0]  flit_data_q, flit_data_d;
  logic [VC_W-1:0]        flit_vc_q, flit_vc_d;

  logic                   emit;
  logic                   credit_ok;
  logic [LEN_W-1:0]       len_in;
  logic [VC_W-1:0]        req_vc_in;
  logic [VC_W-1:0]        accept_vc;

  // A VC index beyond VC_NUM-1 can only occur when VC_NUM is not a power of
  // two; fold it onto the last VC so the credit lookup always stays in range.
  if ((2 ** VC_W) == VC_NUM) begin : g_vc_pow2
    assign req_vc_in = req_vc;
  end else begin : g_vc_clamp
    assign req_vc_in = (req_vc >= VC_W'(VC_NUM)) ? VC_W'(VC_NUM - 1) : req_vc;
  end

`ifdef NOC_PKT_VC_RR_EN
  logic [VC_W-1:0] rr_q, rr_d;

  always_comb begin
    rr_d = rr_q;
    if (req_valid && (state_q == S_IDLE)) begin
      rr_d = (rr_q == VC_W'(VC_NUM - 1)) ? '0 : rr_q + VC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q <= '0;
    end else begin
      rr_q <= rr_d;
    end
  end

  assign accept_vc = rr_q;
`else
  assign accept_vc = req_vc_in;
`endif

  always_comb begin
    len_in = req_len;
    if (req_len == '0) begin
      len_in = LEN_W'(1);
    end else if (req_len > LEN_W'(MAX_PKT_FLITS)) begin
      len_in = LEN_W'(MAX_PKT_FLITS);
    end
  end

  assign credit_ok = (credit_q[vc_q] != '0);

  // FSM next state and flit assembly.
  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    vc_d         = vc_q;
    len_d        = len_q;
    rem_d        = rem_q;
    head_pl_d    = head_pl_q;
    flit_valid_d = 1'b0;
    flit_data_d  = flit_data_q;
    flit_vc_d    = flit_vc_q;
    emit         = 1'b0;
    pl_ready     = 1'b0;
    req_ready    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          x_d       = req_x_dest;
          y_d       = req_y_dest;
          vc_d      = accept_vc;
          len_d     = len_in;
          head_pl_d = req_head_pl;
          state_d   = S_HEAD;
        end
      end

      S_HEAD: begin
        if (credit_ok) begin
          emit         = 1'b1;
          flit_valid_d = 1'b1;
          flit_vc_d    = vc_q;
          if (len_q == LEN_W'(1)) begin
            flit_data_d = {LBL_HEADTAIL, x_q, y_q, head_pl_q};
            state_d     = S_IDLE;
          end else begin
            flit_data_d = {LBL_HEAD, x_q, y_q, head_pl_q};
            rem_d       = len_q - LEN_W'(1);
            state_d     = S_BODY;
          end
        end
      end

      S_BODY: begin
        if (credit_ok && pl_valid) begin
          emit         = 1'b1;
          pl_ready     = 1'b1;
          flit_valid_d = 1'b1;
          flit_vc_d    = vc_q;
          rem_d        = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            flit_data_d = {LBL_TAIL, pl_data};
            state_d     = S_IDLE;
          end else begin
            flit_data_d = {LBL_BODY, pl_data};
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Per-VC credit counters. An emit and a return on the same VC cancel out,
  // so the full-counter overflow check only applies to an unmatched return.
  always_comb begin
    ovf_d = ovf_q;
    for (int v = 0; v < VC_NUM; v++) begin
      credit_d[v] = credit_q[v];
      if ((emit && (vc_q == VC_W'(v))) &&
          !(credit_valid && (credit_vc == VC_W'(v)))) begin
        credit_d[v] = credit_q[v] - CRD_W'(1);
      end else if (!(emit && (vc_q == VC_W'(v))) &&
                   (credit_valid && (credit_vc == VC_W'(v)))) begin
        if (credit_q[v] == CRD_W'(VC_DEPTH)) begin
          ovf_d = 1'b1;
        end else begin
          credit_d[v] = credit_q[v] + CRD_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      x_q          <= '0;
      y_q          <= '0;
      vc_q         <= '0;
      len_q        <= '0;
      rem_q        <= '0;
      head_pl_q    <= '0;
      ovf_q        <= 1'b0;
      flit_valid_q <= 1'b0;
      flit_data_q  <= '0;
      flit_vc_q    <= '0;
      for (int v = 0; v < VC_NUM; v++) begin
        credit_q[v] <= CRD_W'(VC_DEPTH);
      end
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      vc_q         <= vc_d;
      len_q        <= len_d;
      rem_q        <= rem_d;
      head_pl_q    <= head_pl_d;
      ovf_q        <= ovf_d;
      flit_valid_q <= flit_valid_d;
      flit_data_q  <= flit_data_d;
      flit_vc_q    <= flit_vc_d;
      for (int v = 0; v < VC_NUM; v++) begin
        credit_q[v] <= credit_d[v];
      end
    end
  end

  assign flit_valid = flit_valid_q;
  assign flit_data  = flit_data_q;
  assign flit_vc    = flit_vc_q;
  assign credit_ovf = ovf_q;

endmodule
